// File: rtl/mips_pkg.sv
// Shared encodings, FSM states, instruction classes and ALU helpers
// for the multi-cycle MIPS core.
package mips_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;

  typedef enum logic [2:0] {
    K_ALU_R, K_ADDI, K_LW, K_SW, K_BRANCH, K_JUMP, K_HALT, K_ILLEGAL
  } kind_t;

  // Classify an instruction; anything outside the subset is illegal.
  function automatic kind_t decode(input logic [5:0] op, input logic [5:0] funct);
    kind_t k;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: k = K_ALU_R;
          default:                               k = K_ILLEGAL;
        endcase
      end
      OP_ADDI:        k = K_ADDI;
      OP_LW:          k = K_LW;
      OP_SW:          k = K_SW;
      OP_BEQ, OP_BNE: k = K_BRANCH;
      OP_J:           k = K_JUMP;
      OP_HALT:        k = K_HALT;
      default:        k = K_ILLEGAL;
    endcase
    return k;
  endfunction

  function automatic alu_op_t funct_alu(input logic [5:0] funct);
    alu_op_t o;
    case (funct)
      FN_SUB:  o = ALU_SUB;
      FN_AND:  o = ALU_AND;
      FN_OR:   o = ALU_OR;
      FN_SLT:  o = ALU_SLT;
      default: o = ALU_ADD;
    endcase
    return o;
  endfunction

  function automatic logic [XLEN-1:0] alu(input alu_op_t op, input logic [XLEN-1:0] a,
                                          input logic [XLEN-1:0] b);
    logic [XLEN-1:0] y;
    case (op)
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SLT: y = {31'b0, ($signed(a) < $signed(b))};
      default: y = a + b;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/mips_mem.sv
// Word-addressed memory array with combinational read and synchronous write;
// contents are not reset so benches can preload them.
module mips_mem
  import mips_pkg::*;
#(
  parameter int unsigned AW = 8
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata
);

  logic [XLEN-1:0] memory [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) memory[addr] <= wdata;
  end

  assign rdata = memory[addr];

endmodule

// File: rtl/mips_regfile.sv
// 32 x 32 register file: two operand read ports, a debug read port and one
// synchronous write port; register 0 always reads zero.
module mips_regfile
  import mips_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic [XLEN-1:0] dbg_data,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd
);

  logic [XLEN-1:0] regFile [0:31];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regFile[i] <= '0;
    end else if (we && (wa != 5'd0)) begin
      regFile[wa] <= wd;
    end
  end

  assign rd1      = (ra1 == 5'd0)      ? '0 : regFile[ra1];
  assign rd2      = (ra2 == 5'd0)      ? '0 : regFile[ra2];
  assign dbg_data = (dbg_addr == 5'd0) ? '0 : regFile[dbg_addr];

endmodule

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS-I subset core: FETCH/DECODE/EXEC/MEM/WB sequencing with
// memory wait states, halt/illegal stop, retire counter and debug read port.
module mips_multicycle_core
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IMEM_AW  = 8,
  parameter int unsigned DMEM_AW  = 8,
  parameter int unsigned MEM_LAT  = 0,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             halted,
  output logic             illegal,
  output logic             retire,
  output logic [31:0]      pc,
  output logic [CNT_W-1:0] instr_count,
  input  logic [4:0]       dbg_addr,
  output logic [31:0]      dbg_data
);

  state_t  state, state_next;
  kind_t   kind;
  alu_op_t alu_op;

  logic [2:0]  wait_cnt;
  logic [31:0] ir, a, b, pc4, res;
  logic [31:0] im_rdata, dm_rdata, rs_data, rt_data;
  logic [31:0] imm_sext, alu_b, alu_y, pc_next;
  logic [4:0]  wa;
  logic        last_wait, finish, halt_retire, rf_we, dm_we, taken;

  assign kind      = decode(ir[31:26], ir[5:0]);
  assign imm_sext  = {{16{ir[15]}}, ir[15:0]};
  assign last_wait = (wait_cnt == 3'(MEM_LAT));
  assign alu_op    = (kind == K_ALU_R) ? funct_alu(ir[5:0]) : ALU_ADD;
  assign alu_b     = (kind == K_ALU_R) ? b : imm_sext;
  assign alu_y     = alu(alu_op, a, alu_b);
  assign taken     = (ir[31:26] == OP_BEQ) ? (a == b) : (a != b);
  assign wa        = (kind == K_ALU_R) ? ir[15:11] : ir[20:16];

  always_comb begin
    pc_next = pc4;
    if (kind == K_JUMP)                 pc_next = {pc4[31:28], ir[25:0], 2'b00};
    else if (kind == K_BRANCH && taken) pc_next = pc4 + (imm_sext << 2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    finish      = 1'b0;
    halt_retire = 1'b0;
    rf_we       = 1'b0;
    dm_we       = 1'b0;
    case (state)
      FETCH:  if (last_wait) state_next = DECODE;
      DECODE: state_next = EXEC;
      EXEC: begin
        case (kind)
          K_ALU_R, K_ADDI: state_next = WB;
          K_LW, K_SW:      state_next = MEM;
          K_BRANCH, K_JUMP: begin
            finish     = 1'b1;
            state_next = FETCH;
          end
          K_HALT: begin
            halt_retire = 1'b1;
            state_next  = HALT;
          end
          default: state_next = HALT;
        endcase
      end
      MEM: begin
        if (last_wait) begin
          if (kind == K_LW) begin
            state_next = WB;
          end else begin
            dm_we      = 1'b1;
            finish     = 1'b1;
            state_next = FETCH;
          end
        end
      end
      WB: begin
        rf_we      = 1'b1;
        finish     = 1'b1;
        state_next = FETCH;
      end
      HALT:    state_next = HALT;
      default: state_next = HALT;
    endcase
  end

  // Datapath latches and architectural status; all updates keyed off the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      ir          <= '0;
      wait_cnt    <= '0;
      a           <= '0;
      b           <= '0;
      pc4         <= '0;
      res         <= '0;
      instr_count <= '0;
      halted      <= 1'b0;
      illegal     <= 1'b0;
      retire      <= 1'b0;
    end else begin
      retire <= finish | halt_retire;
      if (finish | halt_retire) instr_count <= instr_count + CNT_W'(1);
      if (finish) pc <= pc_next;
      if ((state == FETCH) || (state == MEM))
        wait_cnt <= last_wait ? 3'd0 : wait_cnt + 3'd1;
      if ((state == FETCH) && last_wait) ir <= im_rdata;
      if (state == DECODE) begin
        a   <= rs_data;
        b   <= rt_data;
        pc4 <= pc + 32'd4;
      end
      if (state == EXEC) res <= alu_y;
      if ((state == MEM) && last_wait && (kind == K_LW)) res <= dm_rdata;
      if ((state == EXEC) && ((kind == K_HALT) || (kind == K_ILLEGAL))) halted <= 1'b1;
      if ((state == EXEC) && (kind == K_ILLEGAL)) illegal <= 1'b1;
    end
  end

  mips_regfile rf (
    .clk      (clk),
    .rst      (rst),
    .ra1      (ir[25:21]),
    .ra2      (ir[20:16]),
    .dbg_addr (dbg_addr),
    .rd1      (rs_data),
    .rd2      (rt_data),
    .dbg_data (dbg_data),
    .we       (rf_we),
    .wa       (wa),
    .wd       (res)
  );

  mips_mem #(.AW(IMEM_AW)) im (
    .clk   (clk),
    .we    (1'b0),
    .addr  (pc[IMEM_AW+1:2]),
    .wdata (32'd0),
    .rdata (im_rdata)
  );

  mips_mem #(.AW(DMEM_AW)) dm (
    .clk   (clk),
    .we    (dm_we),
    .addr  (res[DMEM_AW+1:2]),
    .wdata (b),
    .rdata (dm_rdata)
  );

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Bench for mips_multicycle_core: an instruction-level model with a per-class
// latency table predicts every cycle's outputs, plus directed literal checks.
module tb_mips_multicycle_core;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rst1 = 1'b0;
  logic        halted, illegal, retire;
  logic [31:0] pc, instr_count, dbg_data;
  logic [4:0]  dbg_addr = 5'd0;
  logic        halted1, illegal1, retire1;
  logic [31:0] pc1, instr_count1, dbg_data1;
  logic [4:0]  dbg_addr1 = 5'd10;

  always #5 clk = ~clk;

  mips_multicycle_core #(.MEM_LAT(0)) dut (
    .clk(clk), .rst(rst), .halted(halted), .illegal(illegal), .retire(retire),
    .pc(pc), .instr_count(instr_count), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  mips_multicycle_core #(.MEM_LAT(1)) dut1 (
    .clk(clk), .rst(rst1), .halted(halted1), .illegal(illegal1), .retire(retire1),
    .pc(pc1), .instr_count(instr_count1), .dbg_addr(dbg_addr1), .dbg_data(dbg_data1)
  );

  int pass_cnt = 0;
  int check_cnt = 0;
  int rot = 0;
  bit model_on = 1'b0;
  bit cmp_on = 1'b0;

  logic [31:0] prog  [0:255];
  logic [31:0] m_dm  [0:255];
  logic [31:0] m_regs[0:31];
  logic [31:0] m_pc;
  logic [31:0] m_count;
  logic        m_halted, m_illegal, m_retire;
  int          m_left;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] r_op(input int rs, input int rt, input int rd,
                                       input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_op(input logic [5:0] op, input int rs, input int rt,
                                       input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  // Cycles from first FETCH cycle to the finishing edge, by instruction class.
  function automatic int lat(input logic [31:0] ins, input int ml);
    logic [5:0] op;
    logic [5:0] fn;
    op = ins[31:26];
    fn = ins[5:0];
    case (op)
      6'h00:   return (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}) ? 4 + ml : 3 + ml;
      6'h08:   return 4 + ml;
      6'h23:   return 5 + 2 * ml;
      6'h2B:   return 4 + 2 * ml;
      default: return 3 + ml;
    endcase
  endfunction

  task automatic m_wr(input logic [4:0] idx, input logic [31:0] v);
    if (idx != 5'd0) m_regs[idx] = v;
  endtask

  task automatic model_step();
    logic [31:0] ins, a, b, simm, pc4, npc, addr;
    bit ill;
    m_retire = 1'b0;
    if (m_halted) return;
    m_left--;
    if (m_left > 0) return;
    ins  = prog[m_pc[9:2]];
    a    = m_regs[ins[25:21]];
    b    = m_regs[ins[20:16]];
    simm = {{16{ins[15]}}, ins[15:0]};
    pc4  = m_pc + 32'd4;
    npc  = pc4;
    addr = a + simm;
    ill  = 1'b0;
    case (ins[31:26])
      6'h00: begin
        case (ins[5:0])
          6'h20:   m_wr(ins[15:11], a + b);
          6'h22:   m_wr(ins[15:11], a - b);
          6'h24:   m_wr(ins[15:11], a & b);
          6'h25:   m_wr(ins[15:11], a | b);
          6'h2A:   m_wr(ins[15:11], ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
          default: ill = 1'b1;
        endcase
      end
      6'h08:   m_wr(ins[20:16], addr);
      6'h23:   m_wr(ins[20:16], m_dm[addr[9:2]]);
      6'h2B:   m_dm[addr[9:2]] = b;
      6'h04:   if (a == b) npc = pc4 + (simm << 2);
      6'h05:   if (a != b) npc = pc4 + (simm << 2);
      6'h02:   npc = {pc4[31:28], ins[25:0], 2'b00};
      6'h3F:   m_halted = 1'b1;
      default: ill = 1'b1;
    endcase
    if (ill) begin
      m_halted  = 1'b1;
      m_illegal = 1'b1;
      return;
    end
    m_retire = 1'b1;
    m_count  = m_count + 32'd1;
    if (!m_halted) begin
      m_pc   = npc;
      m_left = lat(prog[m_pc[9:2]], 0);
    end
  endtask

  initial forever begin
    @(posedge clk);
    if (model_on) model_step();
  end

  // Every-cycle comparison of the MEM_LAT=0 core against the model.
  initial forever begin
    @(negedge clk);
    if (cmp_on) begin
      check("retire", 32'(retire), 32'(m_retire));
      check("pc", pc, m_pc);
      check("instr_count", instr_count, m_count);
      check("halted", 32'(halted), 32'(m_halted));
      check("illegal", 32'(illegal), 32'(m_illegal));
      dbg_addr = 5'(rot);
      #1;
      check($sformatf("dbg_r%0d", rot), dbg_data, m_regs[rot]);
      rot = (rot + 1) % 32;
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      prog[i] = 32'hF800_0000;
      m_dm[i] = 32'd0;
    end
  endtask

  task automatic start();
    cmp_on   = 1'b0;
    model_on = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      dut.im.memory[i] = prog[i];
      dut.dm.memory[i] = m_dm[i];
    end
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_pc      = 32'd0;
    m_count   = 32'd0;
    m_halted  = 1'b0;
    m_illegal = 1'b0;
    m_retire  = 1'b0;
    m_left    = lat(prog[0], 0);
    @(negedge clk);
    rst      = 1'b0;
    model_on = 1'b1;
    cmp_on   = 1'b1;
  endtask

  task automatic wait_halt();
    for (int i = 0; i < 400; i++) begin
      if (halted) break;
      @(negedge clk);
    end
    check("halt_reached", 32'(halted), 32'd1);
  endtask

  task automatic load_prog_b();
    clear_mem();
    m_dm[2]  = 32'd100;
    prog[0]  = i_op(6'h08, 0, 8, 16'd8);
    prog[1]  = i_op(6'h23, 8, 10, 16'd0);
    prog[2]  = i_op(6'h08, 0, 11, 16'd40);
    prog[3]  = i_op(6'h2B, 8, 11, 16'd4);
    prog[4]  = i_op(6'h08, 0, 9, 16'd40);
    prog[5]  = i_op(6'h04, 11, 9, 16'd1);
    prog[6]  = r_op(8, 8, 13, 6'h20);
    prog[7]  = i_op(6'h05, 11, 9, 16'd5);
    prog[8]  = i_op(6'h08, 0, 14, 16'hFFFF);
    prog[9]  = r_op(14, 0, 15, 6'h2A);
    prog[10] = i_op(6'h08, 0, 0, 16'd5);
    prog[11] = {6'h02, 26'd13};
    prog[12] = 32'hF800_0000;
    prog[13] = 32'hFC00_0000;
  endtask

  initial begin
    // lw with one memory wait state: 7 cycles to the finishing edge
    rst1 = 1'b1;
    for (int i = 0; i < 256; i++) begin
      dut1.im.memory[i] = 32'hFC00_0000;
      dut1.dm.memory[i] = 32'd0;
    end
    dut1.im.memory[0] = i_op(6'h23, 0, 10, 16'd8);
    dut1.dm.memory[2] = 32'd100;
    @(negedge clk);
    rst1 = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("lat1_pre_retire", 32'(retire1), 32'd0);
    check("lat1_pre_t2", dbg_data1, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("lat1_retire", 32'(retire1), 32'd1);
    check("lat1_t2", dbg_data1, 32'd100);
    check("lat1_count", instr_count1, 32'd1);

    // add/sub sequence with register setup
    clear_mem();
    prog[0] = i_op(6'h08, 0, 8, 16'd10);
    prog[1] = i_op(6'h08, 0, 9, 16'd20);
    prog[2] = i_op(6'h08, 0, 10, 16'd30);
    prog[3] = r_op(8, 10, 9, 6'h20);
    prog[4] = r_op(9, 8, 12, 6'h22);
    prog[5] = 32'hFC00_0000;
    start();
    check("rst_pc", pc, 32'd0);
    check("rst_count", instr_count, 32'd0);
    check("rst_retire", 32'(retire), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    repeat (16) @(posedge clk);
    @(negedge clk);
    check("add_retire", 32'(retire), 32'd1);
    check("add_count", instr_count, 32'd4);
    check("add_t1", dut.rf.regFile[9], 32'd40);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("sub_gap_quiet", 32'(retire), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("sub_retire", 32'(retire), 32'd1);
    check("sub_t4", dut.rf.regFile[12], 32'd30);
    wait_halt();
    check("a_count", instr_count, 32'd6);
    check("a_pc", pc, 32'h14);

    // memory, branches, jump, slt, $zero
    load_prog_b();
    start();
    repeat (24) @(posedge clk);
    @(negedge clk);
    check("beq_pc", pc, 32'h1C);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("bne_pc", pc, 32'h20);
    wait_halt();
    check("b_dm3", dut.dm.memory[3], 32'd40);
    check("b_t2", dut.rf.regFile[10], 32'd100);
    check("b_t5", dut.rf.regFile[13], 32'd0);
    check("b_t6", dut.rf.regFile[14], 32'hFFFF_FFFF);
    check("b_t7", dut.rf.regFile[15], 32'd1);
    check("b_count", instr_count, 32'd12);
    check("b_pc", pc, 32'h34);
    check("b_illegal", 32'(illegal), 32'd0);
    repeat (3) @(negedge clk);
    check("b_pc_frozen", pc, 32'h34);

    // illegal opcode 0x3E
    clear_mem();
    prog[0] = i_op(6'h08, 0, 8, 16'd1);
    prog[1] = 32'hF800_0000;
    prog[2] = 32'hFC00_0000;
    start();
    wait_halt();
    repeat (2) @(negedge clk);
    check("c_illegal", 32'(illegal), 32'd1);
    check("c_count", instr_count, 32'd1);
    check("c_pc", pc, 32'h4);
    check("c_retire", 32'(retire), 32'd0);

    // reset asserted in the middle of lw
    load_prog_b();
    start();
    repeat (6) @(posedge clk);
    #2;
    check("d_pre_count", instr_count, 32'd1);
    model_on = 1'b0;
    cmp_on   = 1'b0;
    rst      = 1'b1;
    #1;
    check("d_pc", pc, 32'd0);
    check("d_count", instr_count, 32'd0);
    check("d_retire", 32'(retire), 32'd0);
    check("d_halted", 32'(halted), 32'd0);
    check("d_illegal", 32'(illegal), 32'd0);
    check("d_t0", dut.rf.regFile[8], 32'd0);
    repeat (3) @(negedge clk);
    check("d_t2", dut.rf.regFile[10], 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_core.md
# mips_multicycle_core

Parametrised multi-cycle successor to the single-cycle `mips_processor`. It executes a MIPS-I integer subset through a FETCH/DECODE/EXEC/MEM/WB state machine, so each instruction takes 3–5 cycles plus configurable memory wait states. It has separate internal instruction (`im`) and data (`dm`) word arrays, a halt/illegal-opcode mechanism, a retired-instruction counter and a debug register read port. It is the top-level core that benches instantiate and preload hierarchically.

## Interface
- `RESET_PC`, 32'h0000_0000 — PC value after reset.
- `IMEM_AW`, 8 — log2 of the instruction memory depth in words.
- `DMEM_AW`, 8 — log2 of the data memory depth in words.
- `MEM_LAT`, 0 — extra wait cycles per memory access, range 0..7.
- `CNT_W`, 32 — width of the retired-instruction counter.

Ports (clock and reset first):
- `clk` in 1 — single clock; all state changes on its rising edge.
- `rst` in 1 — asynchronous, active-high reset.
- `halted` out 1 — core is stopped in HALT.
- `illegal` out 1 — the stop was caused by an unsupported encoding.
- `retire` out 1 — one-cycle pulse per completed instruction.
- `pc` out 32 — address of the instruction currently in flight.
- `instr_count` out CNT_W — number of retired instructions.
- `dbg_addr` in 5 — debug register index.
- `dbg_data` out 32 — combinational read of `regFile[dbg_addr]`; index 0 reads 0.

## Operation
- Supported instructions:
  - R-type funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed).
  - op 0x08 addi, 0x23 lw, 0x2B sw, 0x04 beq, 0x05 bne, 0x02 j.
  - op 0x3F halt.
- Any other op or funct is illegal: the core enters HALT, sets `illegal=1`, writes no register or memory, and does not retire the instruction.
- Arithmetic is 32-bit two's complement; overflow wraps with no trap. The immediate is sign-extended for addi, lw, sw and branches.
- Addressing is by byte. The `im` index is `pc[IMEM_AW+1:2]`; the `dm` index is `addr[DMEM_AW+1:2]`. Higher bits are ignored (aliasing) and the low 2 bits are ignored (no alignment trap).
- Branch target = PC+4 + (sext(imm)<<2). Jump target = {PC+4[31:28], imm26, 2'b00}.
- Writes to `$zero` are discarded.
- State machine (state name → next state):
  - FETCH → DECODE, after 1+MEM_LAT cycles. Latches `IR`.
  - DECODE → EXEC. Reads A/B and forms PC+4.
  - EXEC:
    - beq, bne and j update PC and finish.
    - R-type and addi go to WB.
    - lw and sw go to MEM.
    - halt goes to HALT.
    - illegal encodings go to HALT with `illegal=1`.
  - MEM: lasts 1+MEM_LAT cycles. lw goes to WB; sw writes `dm` on the last MEM cycle and finishes.
  - WB: writes rd (R-type) or rt (addi, lw) and finishes.
  - "Finish" means: PC ← next PC, `retire` pulses, then return to FETCH.
  - HALT is absorbing; only `rst` leaves it. halt retires (counted) and sets `halted`.
- Cycles per instruction with MEM_LAT=0: R-type/addi 4, lw 5, sw 4, beq/bne/j 3, halt 3. Each memory access adds MEM_LAT cycles.

## Timing
- Reset (asynchronous):
  - state=FETCH, `pc`=RESET_PC, `IR`=0, wait counter=0.
  - All 32 registers = 0, `instr_count`=0.
  - `halted`=0, `illegal`=0, `retire`=0.
  - `im` and `dm` are not cleared.
- After `rst` falls, the first FETCH cycle is the first rising edge.
- `retire` is registered: high for exactly one cycle, the cycle after the finishing edge (coincident with the next FETCH). `instr_count` increments on that same edge and wraps at 2^CNT_W.
- `pc` updates on the finishing edge only. It is stable during all of an instruction's states.
- A WB register write is visible on `dbg_data` the cycle after the WB edge.
- A branch not taken finishes with PC+4 and has the same latency as a taken branch.
- Reset asserted mid-instruction aborts it: no partial register or memory write after the asynchronous assert, and no `retire` pulse.

## Structure
- Package `mips_pkg`:
  - opcode and funct localparams;
  - state enumeration (FETCH, DECODE, EXEC, MEM, WB, HALT);
  - ALU op codes.
- Sub-module `mips_regfile` contains the array `regFile[0:31]`:
  - two combinational read ports plus a debug read port;
  - one synchronous write port;
  - asynchronous clear on reset;
  - `$zero` hardwired.
- Instance names are `rf`, `im` (array `memory`) and `dm` (array `memory`), so benches can preload them hierarchically.

## Test plan
- Preload t0=10, t1=20, t2=30; run `add $t1,$t0,$t2` then `sub $t4,$t1,$t0` → t1=40, t4=30, `instr_count`=2, two `retire` pulses 4 cycles apart.
- Preload `dm.memory[2]`=100, t0=8; run `lw $t2,0($t0)` → t2=100 after 5 cycles (MEM_LAT=0) and after 7 cycles (MEM_LAT=1).
- t3=40; run `sw $t3,4($t0)`, then `beq $t3,$t1,+1` with t1=40 → `dm.memory[3]`=40; the next add is skipped (t5 stays 0) and `pc` jumps by 8.
- `bne` with equal operands → falls through to PC+4 in 3 cycles.
- `addi $t6,$zero,-1`, then `slt $t7,$t6,$zero`, then `addi $zero,$zero,5` → t6=0xFFFFFFFF, t7=1, register 0 still reads 0.
- Execute opcode 0x3F → `halted`=1, `illegal`=0, PC frozen. Separately, execute opcode 0x3E → `illegal`=1 and count not incremented. Asserting `rst` mid-lw → all outputs return to their reset values immediately.
